// File: rtl/tx_timer_multi.sv
// ----------------------------------------------------------------------------
// tx_timer_multi
//   Interval timer for the slave TX path. One of NUM_SEEDS timeout intervals
//   is picked from TIMEOUT_TABLE when a run starts. The timer runs either
//   one-shot or periodic (auto-reload). The selected seed and mode are latched
//   at start, so later changes on TimerSeed/Periodic only matter after the
//   timer has gone back to idle.
//
//   Optional feature macro: TIMER_PAUSE_EN (adds the Pause input).
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-high
//   TimerEn    run request; low returns the timer to idle and clears it
//   TimerSeed  interval select, sampled only on the start edge
//   Periodic   1 = reload after each expiry, 0 = one-shot; sampled on start
//   Pause      (TIMER_PAUSE_EN only) freezes the counter while running
//   Timeout    registered one-cycle pulse at interval expiry
//   Busy       high while the timer is running
//   Count      live counter value
// ----------------------------------------------------------------------------
module tx_timer_multi #(
    parameter int NUM_SEEDS = 4,
    parameter int SEED_W    = 2,
    parameter int CNT_W     = 16,
    parameter logic [NUM_SEEDS*CNT_W-1:0] TIMEOUT_TABLE =
        {16'd44, 16'd59, 16'd29, 16'd14}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              TimerEn,
    input  logic [SEED_W-1:0] TimerSeed,
    input  logic              Periodic,
`ifdef TIMER_PAUSE_EN
    input  logic              Pause,
`endif
    output logic              Timeout,
    output logic              Busy,
    output logic [CNT_W-1:0]  Count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic                timeout_q, timeout_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic                per_q, per_d;

    logic                pause_run;
    logic [CNT_W-1:0]    step_lim;
    logic                step_per;
    logic [CNT_W-1:0]    step_cnt;
    logic                step_en;

`ifdef TIMER_PAUSE_EN
    assign pause_run = Pause;
`else
    assign pause_run = 1'b0;
`endif

    // Table lookup: out-of-range seeds clamp to the last entry, and a zero
    // entry is treated as a one-cycle interval so the counter never needs
    // to compare against zero.
    function automatic logic [CNT_W-1:0] limit_of(input logic [SEED_W-1:0] sel);
        int               idx;
        logic [CNT_W-1:0] raw;
        idx = int'(sel);
        if (idx > NUM_SEEDS - 1) begin
            idx = NUM_SEEDS - 1;
        end
        raw = TIMEOUT_TABLE[idx*CNT_W +: CNT_W];
        return (raw == '0) ? CNT_W'(1) : raw;
    endfunction

    // Next-state logic. The start edge out of IDLE already counts as the
    // first enabled edge, so IDLE and RUN share the same count step, just
    // with the limit/mode taken from the live inputs instead of the latches.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        timeout_d = 1'b0;
        seed_d    = seed_q;
        per_d     = per_q;
        step_lim  = limit_of(seed_q);
        step_per  = per_q;
        step_cnt  = counter_q;
        step_en   = 1'b0;

        if (!TimerEn) begin
            state_d   = IDLE;
            counter_d = CNT_W'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    seed_d   = TimerSeed;
                    per_d    = Periodic;
                    step_lim = limit_of(TimerSeed);
                    step_per = Periodic;
                    step_cnt = CNT_W'(1);
                    step_en  = 1'b1;
                end
                RUN: begin
                    step_en = !pause_run;
                end
                DONE: begin
                    counter_d = '0;
                end
                default: begin
                    state_d   = IDLE;
                    counter_d = CNT_W'(1);
                end
            endcase

            if (step_en) begin
                if (step_cnt >= step_lim) begin
                    timeout_d = 1'b1;
                    if (step_per) begin
                        state_d   = RUN;
                        counter_d = CNT_W'(1);
                    end else begin
                        state_d   = DONE;
                        counter_d = '0;
                    end
                end else begin
                    state_d   = RUN;
                    counter_d = step_cnt + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers; reset aborts any run without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= CNT_W'(1);
            timeout_q <= 1'b0;
            seed_q    <= '0;
            per_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            timeout_q <= timeout_d;
            seed_q    <= seed_d;
            per_q     <= per_d;
        end
    end

    assign Timeout = timeout_q;
    assign Busy    = (state_q == RUN);
    assign Count   = counter_q;

endmodule

// File: tb/tb_tx_timer_multi.sv
// ----------------------------------------------------------------------------
// tb_tx_timer_multi
//   Self-checking bench for tx_timer_multi in its default build. A reference
//   model tracks, per run, how many enabled edges have elapsed since the start
//   edge and derives Timeout/Busy/Count from that number with plain
//   arithmetic. Directed scenarios add literal expectations, then a random
//   phase exercises enable drops, seed and mode changes.
// ----------------------------------------------------------------------------
module tb_tx_timer_multi;

    logic        clk;
    logic        rst;
    logic        TimerEn;
    logic [1:0]  TimerSeed;
    logic        Periodic;
    logic        Timeout;
    logic        Busy;
    logic [15:0] Count;

    int errors = 0;
    int checks = 0;
    int pulseCnt = 0;

    // Model state: whether a run is in progress, edges since its start,
    // the interval chosen at start and the mode chosen at start.
    bit mActive = 0;
    int mK      = 0;
    int mLim    = 1;
    bit mPer    = 0;
    int tbl[4]  = '{14, 29, 59, 44};

    tx_timer_multi dut (
        .clk       (clk),
        .rst       (rst),
        .TimerEn   (TimerEn),
        .TimerSeed (TimerSeed),
        .Periodic  (Periodic),
        .Timeout   (Timeout),
        .Busy      (Busy),
        .Count     (Count)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int limitFor(input int seed);
        int idx;
        int l;
        idx = (seed > 3) ? 3 : seed;
        l = tbl[idx];
        return (l == 0) ? 1 : l;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelEdge();
        if (rst) begin
            mActive = 0;
            mK      = 0;
        end else if (!TimerEn) begin
            mActive = 0;
            mK      = 0;
        end else if (!mActive) begin
            mActive = 1;
            mLim    = limitFor(int'(TimerSeed));
            mPer    = Periodic;
            mK      = 1;
        end else begin
            mK = mK + 1;
            if (!mPer && mK > mLim + 1) mK = mLim + 1;
        end
    endtask

    task automatic expectLit(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Compare every DUT output against what the model says it must be now.
    task automatic checkOutput();
        int expTo;
        int expBusy;
        int expCnt;
        if (!mActive) begin
            expTo = 0; expBusy = 0; expCnt = 1;
        end else if (mPer) begin
            expTo   = (mK % mLim == 0) ? 1 : 0;
            expBusy = 1;
            expCnt  = (mK % mLim) + 1;
        end else begin
            expTo   = (mK == mLim) ? 1 : 0;
            expBusy = (mK < mLim) ? 1 : 0;
            expCnt  = (mK < mLim) ? mK + 1 : 0;
        end
        expectLit("timeout", int'(Timeout), expTo);
        expectLit("busy", int'(Busy), expBusy);
        expectLit("count", int'(Count), expCnt);
        if (Timeout) pulseCnt++;
    endtask

    // Hold the given inputs for n edges, checking after every edge.
    task automatic applyStimulus(input bit en, input int seed, input bit per, input int n);
        for (int i = 0; i < n; i++) begin
            TimerEn   = en;
            TimerSeed = 2'(seed);
            Periodic  = per;
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput();
        end
    endtask

    initial begin
        int r;
        rst       = 1'b1;
        TimerEn   = 1'b0;
        TimerSeed = 2'd0;
        Periodic  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expectLit("reset_timeout", int'(Timeout), 0);
        expectLit("reset_busy", int'(Busy), 0);
        expectLit("reset_count", int'(Count), 1);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 2);

        // Seed 0 one-shot: single pulse after the 14th edge, then DONE.
        $display("[TB] one-shot seed 0");
        pulseCnt = 0;
        applyStimulus(1, 0, 0, 13);
        expectLit("s1_no_early_pulse", int'(Timeout), 0);
        expectLit("s1_count_before", int'(Count), 14);
        applyStimulus(1, 0, 0, 1);
        expectLit("s1_pulse", int'(Timeout), 1);
        expectLit("s1_busy_falls", int'(Busy), 0);
        expectLit("s1_count_done", int'(Count), 0);
        applyStimulus(1, 0, 0, 20);
        expectLit("s1_single_pulse", pulseCnt, 1);

        // Seed 1 periodic for 100 edges: pulses at edges 29, 58, 87.
        $display("[TB] periodic seed 1");
        applyStimulus(0, 0, 0, 1);
        pulseCnt = 0;
        applyStimulus(1, 1, 1, 100);
        expectLit("s2_pulse_count", pulseCnt, 3);

        // Seed change mid-run is ignored; re-enable with seed 1 uses 29.
        $display("[TB] seed change during run");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 4);
        applyStimulus(1, 1, 0, 10);
        expectLit("s3_latched_seed_pulse", int'(Timeout), 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 1, 0, 28);
        expectLit("s3_seed1_no_pulse_yet", int'(Timeout), 0);
        applyStimulus(1, 1, 0, 1);
        expectLit("s3_seed1_pulse", int'(Timeout), 1);

        // Drop at Count=10 aborts; re-enable restarts the full interval.
        $display("[TB] drop and re-enable");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 9);
        expectLit("s4_count10", int'(Count), 10);
        pulseCnt = 0;
        applyStimulus(0, 0, 0, 1);
        expectLit("s4_idle_count", int'(Count), 1);
        applyStimulus(1, 0, 0, 13);
        expectLit("s4_no_pulse", pulseCnt, 0);
        applyStimulus(1, 0, 0, 1);
        expectLit("s4_pulse", int'(Timeout), 1);

        // Asynchronous reset mid-run at Count=20.
        $display("[TB] async reset mid-run");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 1, 0, 19);
        expectLit("s5_count20", int'(Count), 20);
        #2;
        rst     = 1'b1;
        TimerEn = 1'b0;
        mActive = 0;
        mK      = 0;
        #1;
        expectLit("s5_rst_timeout", int'(Timeout), 0);
        expectLit("s5_rst_busy", int'(Busy), 0);
        expectLit("s5_rst_count", int'(Count), 1);
        #2;
        rst = 1'b0;
        pulseCnt = 0;
        applyStimulus(0, 1, 0, 5);
        expectLit("s5_no_pulse_after_rst", pulseCnt, 0);

        // Random phase: long runs with occasional drops and input churn.
        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            applyStimulus(r >= 4, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
